// File: rtl/acq_sequencer.sv
// Gates the source enable, waits a latched settle time, then forwards exactly N samples from one stream.
// Latency: one cycle from selected input valid to out_valid. No downstream backpressure; abort ends a run at once.
module acq_sequencer #(
    parameter int DATA_W = 32,
    parameter int HS_W   = 14,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        source_sel,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic [CNT_W-1:0]  settle_cycles,
    input  logic              sim_valid,
    input  logic [DATA_W-1:0] sim_data,
    input  logic              hs_valid,
    input  logic [HS_W-1:0]   hs_data_a,
    input  logic [HS_W-1:0]   hs_data_b,
    input  logic              adc2308_valid,
    input  logic [DATA_W-1:0] adc2308_data,
    output logic              source_enable,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  sample_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, DONE} state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  settle_q;
    logic [CNT_W-1:0]  settle_cnt;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  next_count;

    assign next_count = sample_count + 1'b1;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = sim_data;
        case (sel_q)
            2'd0: begin
                sel_valid = sim_valid;
                sel_data  = sim_data;
            end
            2'd1: begin
                sel_valid = hs_valid;
                sel_data  = {{(DATA_W-HS_W){1'b0}}, hs_data_a};
            end
            2'd2: begin
                sel_valid = hs_valid;
                sel_data  = {{(DATA_W-HS_W){1'b0}}, hs_data_b};
            end
            default: begin
                sel_valid = adc2308_valid;
                sel_data  = adc2308_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sel_q         <= '0;
            n_q           <= '0;
            settle_q      <= '0;
            settle_cnt    <= '0;
            source_enable <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            sample_count  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            // Abort outranks everything, including a coincident final sample.
            if (abort && state != IDLE) begin
                state         <= IDLE;
                source_enable <= 1'b0;
                busy          <= 1'b0;
                aborted       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort && n_samples != '0) begin
                            sel_q         <= source_sel;
                            n_q           <= n_samples;
                            settle_q      <= settle_cycles;
                            settle_cnt    <= '0;
                            sample_count  <= '0;
                            source_enable <= 1'b1;
                            busy          <= 1'b1;
                            state         <= (settle_cycles == '0) ? ACQUIRE : SETTLE;
                        end
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == settle_q - 1'b1) begin
                            state <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (sel_valid) begin
                            out_valid    <= 1'b1;
                            out_data     <= sel_data;
                            sample_count <= next_count;
                            if (next_count == n_q) begin
                                out_last      <= 1'b1;
                                source_enable <= 1'b0;
                                state         <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
